// File: rtl/mod_updown_counter_pkg.sv
// mod_updown_counter_pkg: mode encodings shared by the counter and its testbench
package mod_updown_counter_pkg;
  typedef enum logic [1:0] {
    CNT_UP     = 2'b00,
    CNT_DOWN   = 2'b01,
    CNT_BOUNCE = 2'b10,
    CNT_HOLD   = 2'b11
  } cnt_mode_e;
endpackage

// File: rtl/mod_updown_counter_if.sv
// mod_updown_counter_if: control and status bundle of the modulo-N counter
interface mod_updown_counter_if
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  cnt_mode_e        mode;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;
  logic             ovf;
  modport master (output clr, en, load, load_val, mode, input count, dir, tc, ovf);
  modport slave  (input clr, en, load, load_val, mode, output count, dir, tc, ovf);
endinterface

// File: rtl/mod_updown_counter_cnt_next_state.sv
// cnt_next_state: one-step successor of count/dir for the selected mode
module cnt_next_state
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] count,
  input  logic             dir,
  input  cnt_mode_e        mode,
  output logic [WIDTH-1:0] next_count,
  output logic             next_dir,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic at_max, at_zero, going_up, turn;
  // A bounce turn flips dir and steps back, so the post-turn value falls out of the new direction
  always_comb begin
    at_max     = count == MAX;
    at_zero    = count == '0;
    going_up   = (mode == CNT_UP) || (mode == CNT_BOUNCE && dir);
    turn       = going_up ? at_max : at_zero;
    wrap       = (mode != CNT_HOLD) && turn;
    next_dir   = mode == CNT_UP ? 1'b1 : mode == CNT_DOWN ? 1'b0 : mode == CNT_BOUNCE ? dir ^ turn : dir;
    next_count = mode == CNT_HOLD ? count :
                 (mode == CNT_UP && at_max) ? '0 :
                 (mode == CNT_DOWN && at_zero) ? MAX :
                 next_dir ? count + 1'b1 : count - 1'b1;
  end
endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-N up/down/bounce counter with load, clear, TC pulse and sticky overflow
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  mod_updown_counter_if.slave  bus
);
  if (WIDTH < 1 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_param
    $error("mod_updown_counter: MODULUS must lie in 2..2**WIDTH");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] count_q, count_d, nxt_count;
  logic             dir_q, dir_d, tc_q, tc_d, ovf_q, ovf_d, nxt_dir, wrap, step;
  cnt_next_state #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_next (
    .count      (count_q),
    .dir        (dir_q),
    .mode       (bus.mode),
    .next_count (nxt_count),
    .next_dir   (nxt_dir),
    .wrap       (wrap)
  );
  // Priority clear > load > step; up/down modes pin dir even on idle edges
  always_comb begin
    step    = bus.en && bus.mode != CNT_HOLD;
    count_d = bus.clr ? '0 : bus.load ? (bus.load_val > MAX ? MAX : bus.load_val) : step ? nxt_count : count_q;
    dir_d   = bus.clr ? 1'b1 : bus.load ? dir_q :
              (step || bus.mode == CNT_UP || bus.mode == CNT_DOWN) ? nxt_dir : dir_q;
    tc_d    = !bus.clr && !bus.load && step && wrap;
    ovf_d   = !bus.clr && (ovf_q || tc_d);
  end
  // State registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end
  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed checks of three counter instances (mod 10, mod 4, mod 16)
`timescale 1ns/1ps
module tb_mod_updown_counter;
  import mod_updown_counter_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  mod_updown_counter_if #(.WIDTH(4)) i10 ();
  mod_updown_counter_if #(.WIDTH(4)) i4 ();
  mod_updown_counter_if #(.WIDTH(4)) i16 ();
  mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u10 (.clk(clk), .rst_n(rst_n), .bus(i10.slave));
  mod_updown_counter #(.WIDTH(4), .MODULUS(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  mod_updown_counter #(.WIDTH(4), .MODULUS(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
  logic [3:0] b_cnt [7] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1};
  logic       b_tc  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       b_dir [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    {i10.clr, i10.en, i10.load, i10.load_val, i10.mode} = {3'b000, 4'd0, CNT_UP};
    {i4.clr, i4.en, i4.load, i4.load_val, i4.mode}      = {3'b000, 4'd0, CNT_UP};
    {i16.clr, i16.en, i16.load, i16.load_val, i16.mode} = {3'b000, 4'd0, CNT_UP};
    tick();
    tick();
    chk("reset_count", 32'(i10.count), 0);
    chk("reset_dir", 32'(i10.dir), 1);
    chk("reset_tc", 32'(i10.tc), 0);
    chk("reset_ovf", 32'(i10.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    i10.en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("up_count_%0d", i), 32'(i10.count), 32'(i % 10));
      chk($sformatf("up_tc_%0d", i), 32'(i10.tc), 32'(i == 10));
      chk($sformatf("up_ovf_%0d", i), 32'(i10.ovf), 32'(i == 10));
    end
    tick();
    chk("up_after_wrap_tc", 32'(i10.tc), 0);
    chk("up_ovf_sticky", 32'(i10.ovf), 1);
    i10.clr = 1'b1;
    tick();
    chk("clr_count", 32'(i10.count), 0);
    chk("clr_ovf", 32'(i10.ovf), 0);
    chk("clr_dir", 32'(i10.dir), 1);
    i10.clr = 1'b0;
    i10.mode = CNT_DOWN;
    tick();
    chk("down_count_9", 32'(i10.count), 9);
    chk("down_tc_9", 32'(i10.tc), 1);
    chk("down_dir", 32'(i10.dir), 0);
    chk("down_ovf", 32'(i10.ovf), 1);
    tick();
    chk("down_count_8", 32'(i10.count), 8);
    chk("down_tc_8", 32'(i10.tc), 0);
    tick();
    chk("down_count_7", 32'(i10.count), 7);
    i10.en = 1'b0;
    i10.load = 1'b1;
    i10.load_val = 4'd12;
    tick();
    chk("load_clamp", 32'(i10.count), 9);
    chk("load_clamp_tc", 32'(i10.tc), 0);
    i10.load_val = 4'd5;
    i10.en = 1'b1;
    tick();
    chk("load_over_en", 32'(i10.count), 5);
    chk("load_keeps_dir", 32'(i10.dir), 0);
    chk("load_keeps_ovf", 32'(i10.ovf), 1);
    i10.clr = 1'b1;
    tick();
    chk("clr_over_load_count", 32'(i10.count), 0);
    chk("clr_over_load_ovf", 32'(i10.ovf), 0);
    i10.clr = 1'b0;
    i10.load_val = 4'd6;
    tick();
    chk("load_6", 32'(i10.count), 6);
    i10.load = 1'b0;
    i10.en = 1'b0;
    i10.mode = CNT_UP;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_count_%0d", i), 32'(i10.count), 6);
      chk($sformatf("hold_tc_%0d", i), 32'(i10.tc), 0);
    end
    i10.clr = 1'b1;
    tick();
    i10.clr = 1'b0;
    i10.en = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    chk("pre_rst_count", 32'(i10.count), 7);
    chk("pre_rst_ovf", 32'(i10.ovf), 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(i10.count), 0);
    chk("async_rst_ovf", 32'(i10.ovf), 0);
    chk("async_rst_dir", 32'(i10.dir), 1);
    #1 rst_n = 1'b1;
    tick();
    chk("resume_count", 32'(i10.count), 1);
    i10.en = 1'b0;
    i4.mode = CNT_BOUNCE;
    i4.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("bounce_count_%0d", i), 32'(i4.count), 32'(b_cnt[i]));
      chk($sformatf("bounce_tc_%0d", i), 32'(i4.tc), 32'(b_tc[i]));
      chk($sformatf("bounce_dir_%0d", i), 32'(i4.dir), 32'(b_dir[i]));
    end
    i4.en = 1'b0;
    i16.en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("mod16_count_%0d", i), 32'(i16.count), 32'(i % 16));
      chk($sformatf("mod16_tc_%0d", i), 32'(i16.tc), 32'(i == 16));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
